// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// No logic; imported by the interface, buffer and controller.
package fetch_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_if.sv
// Fetch bundle: imem req/ack, execute redirect, IF/ID valid/ready.
// master = fetch controller side, slave = memory/decode/execute side.
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_ready;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// 2-entry IF/ID FIFO of {pc, instr}; push visible at head next cycle.
// No internal backpressure: caller never pushes when full; flush beats push/pop.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);
    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_controller.sv
// Owns the PC, issues imem fetches, feeds decode through fetch_buffer; ack-to-id_valid 1 cycle.
// Fetch stalls while the buffer is full; a redirect over an un-acked request drains it first.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic    clk,
    input logic    reset,
    fetch_if.master bus
);
    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] drain_addr;
    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            redirect;
    logic            push;
    logic            pop;

    assign redirect = bus.redirect_valid && (state != IDLE);

    // A held request only ever sees count fall, so req/addr stay stable until ack.
    assign bus.imem_req  = (state == DRAIN) || ((state == RUN) && (count != 2'd2));
    assign bus.imem_addr = (state == DRAIN) ? drain_addr : pc;

    assign bus.id_valid = (count != 2'd0) && !bus.redirect_valid;
    assign bus.id_pc    = head.pc;
    assign bus.id_instr = head.instr;

    assign push      = (state == RUN) && bus.imem_req && bus.imem_ack && !redirect;
    assign pop       = bus.id_valid && bus.id_ready;
    assign push_data = '{pc: pc, instr: bus.imem_rdata};

    fetch_buffer u_fetch_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= '0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (redirect) begin
                        pc <= align_word(bus.redirect_pc);
                        if (bus.imem_req && !bus.imem_ack) begin
                            drain_addr <= pc;
                            state      <= DRAIN;
                        end
                    end else if (bus.imem_req && bus.imem_ack) begin
                        pc <= pc + XLEN'(INSTR_BYTES);
                    end
                end
                DRAIN: begin
                    // The stale response is swallowed; the new pc is fetched once back in RUN.
                    if (redirect) begin
                        pc <= align_word(bus.redirect_pc);
                    end
                    if (bus.imem_ack) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench: the reference model predicts the in-order pc stream from reset/redirect targets.
module tb_fetch_controller;
    import fetch_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_if bus ();
    fetch_if bus2 ();

    fetch_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    assign bus2.imem_ack       = 1'b1;
    assign bus2.imem_rdata     = mem_fn(bus2.imem_addr);
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 32'h0;
    assign bus2.id_ready       = 1'b1;

    int          checks    = 0;
    int          errors    = 0;
    int          delivered = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_next;
    int          max_wait  = 0;
    int          ready_pct = 100;
    bit          hold_ack  = 1'b0;
    bit          new_req   = 1'b1;
    int          wait_cnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_restart(input logic [31:0] start);
        exp_q.delete();
        model_next = {start[31:2], 2'b00};
    endtask

    task automatic model_topup();
        while (exp_q.size() < 4) begin
            exp_q.push_back(model_next);
            model_next = model_next + 32'd4;
        end
    endtask

    // Memory with a random number of wait states per request.
    task automatic drive_mem();
        if (!bus.imem_req) begin
            bus.imem_ack = 1'b0;
            new_req      = 1'b1;
        end else if (hold_ack) begin
            bus.imem_ack = 1'b0;
        end else begin
            if (new_req) begin
                wait_cnt = $urandom_range(max_wait, 0);
                new_req  = 1'b0;
            end
            if (wait_cnt == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_fn(bus.imem_addr);
                new_req        = 1'b1;
            end else begin
                bus.imem_ack = 1'b0;
                wait_cnt--;
            end
        end
    endtask

    task automatic step(input bit redir = 1'b0, input logic [31:0] tgt = 32'h0);
        @(posedge clk);
        #1;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        if (redir) model_restart(tgt);
        bus.id_ready = ($urandom_range(99, 0) < ready_pct);
        drive_mem();
        model_topup();
    endtask

    // Reset is asserted alongside a redirect and an ack to show reset wins.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset              = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h700;
        bus.imem_ack       = 1'b1;
        bus.imem_rdata     = 32'hDEAD_BEEF;
        bus.id_ready       = 1'b1;
        hold_ack           = 1'b0;
        new_req            = 1'b1;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.imem_ack       = 1'b0;
        @(negedge clk);
        check("rst_req",   bus.imem_req,  32'h0);
        check("rst_addr",  bus.imem_addr, 32'h0);
        check("rst_valid", bus.id_valid,  32'h0);
        check("rst_instr", bus.id_instr,  32'h0);
        check("rst_pc",    bus.id_pc,     32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_restart(32'h0);
        bus.id_ready = ($urandom_range(99, 0) < ready_pct);
        drive_mem();
        model_topup();
    endtask

    // Monitor: handshake stability, id_valid masking, and in-order delivery.
    initial begin
        bit          pending = 1'b0;
        logic [31:0] paddr   = 32'h0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (pending) begin
                check("hold_req",  bus.imem_req,  32'h1);
                check("hold_addr", bus.imem_addr, paddr);
            end
            pending = !reset && bus.imem_req && !bus.imem_ack;
            paddr   = bus.imem_addr;
            if (!reset && bus.redirect_valid) check("valid_on_redirect", bus.id_valid, 32'h0);
            if (!reset && bus.id_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deliver: got id_pc %h expected nothing", bus.id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc",    bus.id_pc,    e);
                    check("id_instr", bus.id_instr, mem_fn(e));
                    delivered++;
                end
            end
        end
    end

    initial begin
        logic [31:0] exp2;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b1;

        // Zero-wait streaming, also for the wrap-around instance.
        do_reset();
        @(negedge clk);
        check("c0_req", bus.imem_req, 32'h0);
        step();
        @(negedge clk);
        check("c1_req",  bus.imem_req,  32'h1);
        check("c1_addr", bus.imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            exp2 = 32'hFFFF_FFF8 + 32'(i * 4);
            check("seq_valid",   bus.id_valid,   32'h1);
            check("seq_pc",      bus.id_pc,      32'(i * 4));
            check("wrap_valid",  bus2.id_valid,  32'h1);
            check("wrap_pc",     bus2.id_pc,     exp2);
            check("wrap_instr",  bus2.id_instr,  mem_fn(exp2));
        end
        repeat (10) step();

        // Wait states, random backpressure and random redirects.
        max_wait = 3;
        repeat (60) step();
        ready_pct = 60;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(15, 0) == 0) step(1'b1, $urandom);
            else step();
        end

        // Backpressure fills the buffer, then fetch resumes at 8.
        max_wait  = 0;
        ready_pct = 0;
        do_reset();
        repeat (6) step();
        @(negedge clk);
        check("bp_req",   bus.imem_req, 32'h0);
        check("bp_valid", bus.id_valid, 32'h1);
        check("bp_head",  bus.id_pc,    32'h0);
        ready_pct = 100;
        step();
        step();
        @(negedge clk);
        check("resume_req",  bus.imem_req,  32'h1);
        check("resume_addr", bus.imem_addr, 32'h8);

        // Redirect while the fetch of 8 is waiting.
        do_reset();
        step();
        step();
        hold_ack = 1'b1;
        step();
        @(negedge clk);
        check("wait_addr", bus.imem_addr, 32'h8);
        step(1'b1, 32'h100);
        step();
        @(negedge clk);
        check("drain_req",  bus.imem_req,  32'h1);
        check("drain_addr", bus.imem_addr, 32'h8);
        hold_ack = 1'b0;
        step();
        step();
        @(negedge clk);
        check("post_drain_addr", bus.imem_addr, 32'h100);
        step();
        @(negedge clk);
        check("redir_valid", bus.id_valid, 32'h1);
        check("redir_pc",    bus.id_pc,    32'h100);

        // Redirect coincident with ack, then a second redirect during DRAIN.
        repeat (3) step();
        step(1'b1, 32'h300);
        hold_ack = 1'b1;
        step(1'b1, 32'h400);
        @(negedge clk);
        check("ack_redir_addr", bus.imem_addr, 32'h300);
        step(1'b1, 32'h200);
        @(negedge clk);
        check("drain2_addr", bus.imem_addr, 32'h300);
        hold_ack = 1'b0;
        step();
        step();
        @(negedge clk);
        check("redir2_addr", bus.imem_addr, 32'h200);
        step();
        @(negedge clk);
        check("redir2_pc", bus.id_pc, 32'h200);

        // Unaligned target.
        repeat (2) step();
        step(1'b1, 32'h103);
        step();
        @(negedge clk);
        check("align_addr", bus.imem_addr, 32'h100);
        step();
        @(negedge clk);
        check("align_pc", bus.id_pc, 32'h100);

        // Reset while draining.
        hold_ack = 1'b1;
        step();
        step(1'b1, 32'h500);
        step();
        @(negedge clk);
        check("g_drain_req", bus.imem_req, 32'h1);
        do_reset();
        step();
        step();
        @(negedge clk);
        check("g_restart_valid", bus.id_valid, 32'h1);
        check("g_restart_pc",    bus.id_pc,    32'h0);

        repeat (5) step();
        check("progress", 32'(delivered >= 60), 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch for the RISC-V core: owns the PC, issues word fetches to the instruction memory over a req/ack handshake with arbitrary wait states, and buffers returned instructions in a 2-entry queue toward decode (IF/ID) under valid/ready flow control. It also applies control-flow redirects from execute, including the case where a redirect lands while a memory access is still in flight. It replaces the free-running PC+4 fetch loop in the pipelined design.

## Interface
- RESET_PC, 32'h0000_0000, fetch address issued first after reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch byte address, word aligned
- imem_ack  in  1  memory completes the request this cycle; meaningful only while imem_req=1
- imem_rdata  in  32  instruction word, valid when imem_req&&imem_ack
- redirect_valid  in  1  one-cycle pulse: branch/jump taken, flush and refetch
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated as 0)
- id_valid  out  1  instruction available to decode
- id_instr  out  32  instruction word
- id_pc  out  32  address of id_instr
- id_ready  in  1  decode accepts; transfer when id_valid&&id_ready

## Operation
- FSM states: IDLE (reset state, one cycle, imem_req=0) -> RUN; RUN -> DRAIN on redirect with an un-acked request; DRAIN -> RUN on imem_ack.
- Registers: pc (next fetch address), drain_addr, fetch buffer (2 entries of {pc, instr}, count 0..2).
- RUN: imem_req = (count < 2); imem_addr = pc. On req&&ack: push {pc, imem_rdata}, pc <= pc+4.
- Handshake rule: once imem_req is high, imem_req and imem_addr stay constant until the ack cycle. Since count only decreases while waiting, no new condition can drop the request; only a redirect can retarget, and that retarget goes through DRAIN.
- Buffer: id_valid = (count != 0) && !redirect_valid; id_pc/id_instr = head entry. Pop on id_valid&&id_ready. Push and pop in the same cycle leave count unchanged. The push at count==1 with a simultaneous pop is legal.
- Redirect (any state except IDLE):
  - Buffer flushed (count <= 0). No pop occurs that cycle.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - If imem_req=1 and imem_ack=0: drain_addr <= current imem_addr, go to DRAIN.
  - If imem_req&&imem_ack: the response is discarded and is not pushed. Stay in RUN.
  - If imem_req=0 (buffer full): stay in RUN.
- DRAIN: imem_req=1, imem_addr=drain_addr. On ack, the data is discarded and the state goes to RUN; the fetch of pc starts the next cycle. A redirect in DRAIN updates pc only and the state stays in DRAIN. No pushes occur in DRAIN.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset wins over redirect and ack in the same cycle. A request in flight at reset is abandoned. The memory must tolerate req dropping (team memory contract).

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, count=0, state=IDLE, pc=RESET_PC.
- Cycle 0 after reset deasserts: IDLE. Cycle 1: first imem_req.
- Acked fetch to id_valid: 1 cycle (registered buffer). With imem_ack tied high, throughput is 1 instr/cycle and the first id_valid is in cycle 2.
- Redirect penalty with zero-wait memory: redirect in cycle t; redirect_pc requested in t+1; id_valid with id_pc=redirect_pc in t+2.
- id_valid has a combinational path from redirect_valid only. All other outputs come from registers or the FSM state.

## Structure
- Shared package fetch_pkg:
  - XLEN=32, INSTR_BYTES=4.
  - FSM state typedef {IDLE, RUN, DRAIN}.
  - fetch entry struct {pc, instr}.
- Sub-module fetch_buffer:
  - 2-entry synchronous FIFO.
  - Ports: push/pop/flush, head data, count.
  - Same clk/reset convention.
- fetch_controller holds the FSM, pc, drain_addr and the handshake.

## Test plan
- Reset, imem_ack=1, id_ready=1 -> id_pc sequence 0,4,8,C starting cycle 2. All outputs hold reset values during reset.
- imem_ack delayed 3 cycles per fetch -> imem_addr stable while waiting. Each instruction is delivered once with the correct id_pc. No duplicates.
- id_ready=0 for 6 cycles -> count reaches 2 and imem_req drops. Releasing id_ready resumes fetch at pc=8 with no loss.
- Redirect to 32'h100 while a request to 32'h8 is waiting 2 cycles -> DRAIN keeps addr 8 until ack. Data is discarded. The next req is 32'h100 and id_pc=32'h100 is delivered. No stale entries.
- Redirect coincident with ack, and a second redirect to 32'h200 during DRAIN -> only 32'h200 is delivered next. Redirect_pc 32'h103 fetches 32'h100.
- RESET_PC=32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Reset asserted during DRAIN -> IDLE next cycle, imem_req=0.
